// File: rtl/huffman_pkg.sv
// Shared types and constants for the huffman decode scheduler: FSM encoding,
// field widths and the reference code table.
package huffman_pkg;

    localparam int CODE_W  = 4;
    localparam int LEN_W   = 3;
    localparam int SYM_W   = 3;
    localparam int NUM_SYM = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Code table, bits in send order (MSB first), right-aligned.
    localparam logic [CODE_W-1:0] CT_CODE [NUM_SYM] = '{
        4'b0010, 4'b0011, 4'b0001, 4'b0010, 4'b0011, 4'b0000, 4'b0001
    };
    localparam logic [LEN_W-1:0] CT_LEN [NUM_SYM] = '{
        3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4
    };
    localparam logic [SYM_W-1:0] CT_SYM [NUM_SYM] = '{
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6
    };

endpackage

// File: rtl/hdec_rr_arbiter.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping upward.
// Purely combinational; returns one-hot winner, its index and an any-request flag.
module hdec_rr_arbiter
    import huffman_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [PTR_W-1:0]   win_idx,
    output logic               win_any
);

    int              jj;
    logic [PTR_W-1:0] j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        jj      = 0;
        j       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            jj = int'(rr_ptr) + i;
            if (jj >= NUM_REQ) jj = jj - NUM_REQ;
            j = PTR_W'(jj);
            if (!win_any && req[j]) begin
                win_any    = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = j;
            end
        end
    end

endmodule

// File: rtl/huffman_decode_sched.sv
// Round-robin scheduler sharing one bit-serial huffman_decode among NUM_REQ requesters.
// Optional WAIT timeout is enabled by defining HDEC_SCHED_TIMEOUT_EN.
module huffman_decode_sched
    import huffman_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = huffman_pkg::CODE_W,
    parameter int LEN_W   = huffman_pkg::LEN_W,
    parameter int SYM_W   = huffman_pkg::SYM_W
`ifdef HDEC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 8
`endif
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CODE_W-1:0]  code,
    input  logic [NUM_REQ*LEN_W-1:0]   len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [SYM_W-1:0]           rsp_symbol,
    output logic                       rsp_err,
    output logic                       dec_nrst,
    output logic                       dec_serial,
    input  logic [SYM_W-1:0]           dec_status,
    input  logic                       dec_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_any;
    logic [CODE_W-1:0]  win_code;
    logic [CODE_W-1:0]  aligned;
    logic [CODE_W-1:0]  shreg;
    logic [LEN_W-1:0]   win_len;
    logic [LEN_W-1:0]   align_sh;
    logic [LEN_W-1:0]   bitcnt;
    logic               len_ok;
    logic               dec_nrst_q;

`ifdef HDEC_SCHED_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0]  tcnt;
`endif

    hdec_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    // Winner's code is left-aligned so the shifter always emits the top bit.
    always_comb begin
        win_code = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_code = code[i*CODE_W +: CODE_W];
                win_len  = len[i*LEN_W +: LEN_W];
            end
        end
        len_ok   = (win_len >= LEN_W'(2)) && (win_len <= LEN_W'(CODE_W));
        align_sh = LEN_W'(CODE_W) - win_len;
        aligned  = win_code << align_sh;
    end

    assign dec_nrst = dec_nrst_q & nrst;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= S_IDLE;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_symbol <= '0;
            rsp_err    <= 1'b0;
            dec_nrst_q <= 1'b0;
            dec_serial <= 1'b1;
            rr_ptr     <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    dec_nrst_q <= 1'b0;
                    dec_serial <= 1'b1;
                    // The requester just served may still show req this cycle.
                    if (|(req & ~rsp_valid)) state <= S_ARB;
                end
                S_ARB: begin
                    if (!win_any) begin
                        state <= S_IDLE;
                    end else begin
                        gnt        <= win_oh;
                        rr_ptr     <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                        rsp_symbol <= '0;
                        rsp_err    <= 1'b0;
                        if (len_ok) begin
                            dec_nrst_q <= 1'b1;
                            dec_serial <= aligned[CODE_W-1];
                            shreg      <= aligned << 1;
                            bitcnt     <= win_len - LEN_W'(1);
                            state      <= S_SHIFT;
                        end else begin
                            rsp_err <= 1'b1;
                            state   <= S_RESP;
                        end
                    end
                end
                S_SHIFT: begin
                    if (dec_valid) begin
                        rsp_err    <= 1'b1;
                        dec_nrst_q <= 1'b0;
                        dec_serial <= 1'b1;
                        state      <= S_RESP;
                    end else if (bitcnt == '0) begin
                        dec_serial <= 1'b1;
                        state      <= S_WAIT;
`ifdef HDEC_SCHED_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                    end else begin
                        dec_serial <= shreg[CODE_W-1];
                        shreg      <= shreg << 1;
                        bitcnt     <= bitcnt - LEN_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dec_valid) begin
                        rsp_symbol <= dec_status;
                        dec_nrst_q <= 1'b0;
                        state      <= S_RESP;
                    end
`ifdef HDEC_SCHED_TIMEOUT_EN
                    else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        rsp_err    <= 1'b1;
                        rsp_symbol <= '0;
                        dec_nrst_q <= 1'b0;
                        state      <= S_RESP;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    rsp_valid  <= gnt;
                    gnt        <= '0;
                    dec_nrst_q <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_decode_sched.sv
// Bench for huffman_decode_sched with a behavioural bit-serial decoder behind it.
// Timeout scenario is included when HDEC_SCHED_TIMEOUT_EN is defined.
module tb_huffman_decode_sched;
    import huffman_pkg::*;

    localparam int NR = 4;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic [NR-1:0]         req;
    logic [NR*CODE_W-1:0]  code;
    logic [NR*LEN_W-1:0]   len;
    logic [NR-1:0]         gnt;
    logic [NR-1:0]         rsp_valid;
    logic [SYM_W-1:0]      rsp_symbol;
    logic                  rsp_err;
    logic                  dec_nrst;
    logic                  dec_serial;
    logic [SYM_W-1:0]      dec_status;
    logic                  dec_valid;

    logic [CODE_W-1:0]     c_arr [NR];
    logic [LEN_W-1:0]      l_arr [NR];
    logic                  dec_mute;
    logic                  dec_bits [$];
    int                    checks = 0;
    int                    errors = 0;
    int                    m_ptr;
    logic                  low_seen;

    always #5 clk = ~clk;

    always_comb begin
        code = '0;
        len  = '0;
        for (int i = 0; i < NR; i++) begin
            code[i*CODE_W +: CODE_W] = c_arr[i];
            len[i*LEN_W +: LEN_W]    = l_arr[i];
        end
    end

    huffman_decode_sched #(.NUM_REQ(NR)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .code       (code),
        .len        (len),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_symbol (rsp_symbol),
        .rsp_err    (rsp_err),
        .dec_nrst   (dec_nrst),
        .dec_serial (dec_serial),
        .dec_status (dec_status),
        .dec_valid  (dec_valid)
    );

    // Behavioural decoder: walks the code table one bit per clock, pulses valid on a match.
    logic [7:0] acc_val, nxt_val;
    int         acc_len, nxt_len;
    logic       nxt_hit;
    logic [SYM_W-1:0] nxt_sym;

    always_comb begin
        nxt_val = {acc_val[6:0], dec_serial};
        nxt_len = acc_len + 1;
        nxt_hit = 1'b0;
        nxt_sym = '0;
        for (int i = 0; i < NUM_SYM; i++)
            if (nxt_len == int'(CT_LEN[i]) && nxt_val == 8'(CT_CODE[i])) begin
                nxt_hit = 1'b1;
                nxt_sym = CT_SYM[i];
            end
    end

    always @(posedge clk) begin
        if (!dec_nrst) begin
            acc_val    <= '0;
            acc_len    <= 0;
            dec_valid  <= 1'b0;
            dec_status <= '0;
        end else begin
            dec_bits.push_back(dec_serial);
            if (nxt_hit) begin
                acc_val    <= '0;
                acc_len    <= 0;
                dec_valid  <= !dec_mute;
                dec_status <= nxt_sym;
            end else begin
                acc_val    <= nxt_val;
                acc_len    <= nxt_len;
                dec_valid  <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the code table: stream = code bits MSB first, then idle 1s.
    task automatic ref_model(input logic [CODE_W-1:0] c, input int l, input logic mute,
                             output logic e_err, output logic [SYM_W-1:0] e_sym,
                             output int e_lat, output int e_nb, output logic [7:0] e_bits);
        int p;
        logic [7:0] v;
        logic hit;
        e_bits = '0;
        e_sym  = '0;
        if (l < 2 || l > CODE_W) begin
            e_err = 1'b1; e_lat = 1; e_nb = 0;
            return;
        end
        v = '0; p = 0; hit = 1'b0;
        while (!hit && p < 8) begin
            p++;
            v = {v[6:0], (p <= l) ? c[l-p] : 1'b1};
            for (int i = 0; i < NUM_SYM; i++)
                if (int'(CT_LEN[i]) == p && v == 8'(CT_CODE[i])) begin
                    hit = 1'b1;
                    e_sym = CT_SYM[i];
                end
        end
        e_nb = (p < l) ? p : l;
        for (int i = 1; i <= e_nb; i++) e_bits = {e_bits[6:0], c[l-i]};
        if (mute) begin
            e_err = 1'b1; e_sym = '0; e_lat = l + 9;
        end else if (p < l) begin
            e_err = 1'b1; e_sym = '0; e_lat = p + 2;
        end else begin
            e_err = 1'b0; e_lat = p + 2;
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
        for (int i = 0; i < NR; i++)
            if (r[(ptr + i) % NR]) return (ptr + i) % NR;
        return 0;
    endfunction

    task automatic post(input int r, input logic [CODE_W-1:0] c, input int l);
        c_arr[r] = c;
        l_arr[r] = LEN_W'(l);
        req[r]   = 1'b1;
    endtask

    // Serve every posted request, dropping each req when its own response pulses.
    task automatic service(input int budget);
        int cyc, gstart, cur, e_lat, e_nb;
        logic active;
        logic [NR-1:0] prev_gnt;
        logic e_err;
        logic [SYM_W-1:0] e_sym;
        logic [7:0] e_bits, ob;
        cyc = 0; gstart = 0; cur = 0; active = 1'b0; prev_gnt = '0;
        e_err = 1'b0; e_sym = '0; e_lat = 0; e_nb = 0; e_bits = '0;
        while ((req != '0 || active) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0 && prev_gnt == '0) begin
                cur = rr_pick(req, m_ptr);
                chk("gnt_onehot", 32'(gnt), 32'(1 << cur));
                chk("dec_reset_gap", 32'(low_seen), 32'd1);
                m_ptr = (cur + 1) % NR;
                gstart = cyc;
                active = 1'b1;
                low_seen = 1'b0;
                dec_bits.delete();
                ref_model(c_arr[cur], int'(l_arr[cur]), dec_mute, e_err, e_sym, e_lat, e_nb, e_bits);
            end
            if (rsp_valid != '0) begin
                chk("rsp_valid", 32'(rsp_valid), 32'(1 << cur));
                chk("rsp_symbol", 32'(rsp_symbol), 32'(e_sym));
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
                chk("latency", 32'(cyc - gstart), 32'(e_lat));
                if (e_nb == 0) begin
                    chk("no_dec_bits", 32'(dec_bits.size()), 32'd0);
                end else begin
                    ob = '0;
                    for (int i = 0; i < e_nb; i++)
                        ob = {ob[6:0], (i < dec_bits.size()) ? dec_bits[i] : 1'bx};
                    chk("serial_bits", 32'(ob), 32'(e_bits));
                end
                req = req & ~rsp_valid;
                active = 1'b0;
            end
            if (!dec_nrst) low_seen = 1'b1;
            prev_gnt = gnt;
        end
        chk("service_done", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        nrst = 1'b0; req = '0; dec_mute = 1'b0; m_ptr = 0; low_seen = 1'b0;
        for (int i = 0; i < NR; i++) begin c_arr[i] = '0; l_arr[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_symbol", 32'(rsp_symbol), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_dec_nrst", 32'(dec_nrst), 32'd0);
        chk("rst_dec_serial", 32'(dec_serial), 32'd1);
        nrst = 1'b1;
        @(negedge clk);

        // All four held together
        post(0, 4'b0010, 2); post(1, 4'b0001, 4); post(2, 4'b0000, 4); post(3, 4'b0010, 3);
        service(200);
        // Single short and 3-bit codes
        post(0, 4'b0011, 2); service(50);
        post(1, 4'b0011, 3); service(50);
        post(1, 4'b0010, 3); service(50);
        post(1, 4'b0001, 3); service(50);
        // Illegal lengths and a code/len mismatch
        post(2, 4'b0011, 1); service(50);
        post(2, 4'b0011, 5); service(50);
        post(2, 4'b0100, 3); service(50);
        post(3, 4'b0001, 2); service(50);

`ifdef HDEC_SCHED_TIMEOUT_EN
        dec_mute = 1'b1;
        post(0, 4'b0000, 3); service(60);
        dec_mute = 1'b0;
`endif

        // Randomised request sets mixing table codes and arbitrary code/len pairs
        for (int round = 0; round < 25; round++) begin
            for (int r = 0; r < NR; r++) begin
                if ($urandom_range(0, 1) == 1 || (r == NR - 1 && req == '0)) begin
                    if ($urandom_range(0, 9) < 7) begin
                        int idx;
                        idx = $urandom_range(0, NUM_SYM - 1);
                        post(r, CT_CODE[idx], int'(CT_LEN[idx]));
                    end else begin
                        post(r, CODE_W'($urandom), $urandom_range(0, 7));
                    end
                end
            end
            service(400);
        end

        // Abort during SHIFT, then the still-pending request is served afresh
        post(1, 4'b0011, 3);
        for (int i = 0; i < 20 && gnt == '0; i++) @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'b0010);
        nrst = 1'b0;
        #1;
        chk("abort_dec_nrst_now", 32'(dec_nrst), 32'd0);
        @(negedge clk);
        chk("abort_gnt_rst", 32'(gnt), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_symbol", 32'(rsp_symbol), 32'd0);
        chk("abort_rsp_err", 32'(rsp_err), 32'd0);
        chk("abort_dec_serial", 32'(dec_serial), 32'd1);
        @(negedge clk);
        chk("abort_no_pulse", 32'(rsp_valid), 32'd0);
        nrst = 1'b1;
        m_ptr = 0;
        service(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
